// File: rtl/result_display.sv
// result_display: double-dabble binary-to-BCD converter feeding an
// eight-digit multiplexed 7-segment display (active-low segments/anodes).
// Optional macro RESULT_DISPLAY_SIGNED_EN: treat value as two's complement
// and show a leading '-' for negative results.
module result_display #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [6:0]  seg,
    output logic [7:0]  an
);

    localparam int CW = $clog2(REFRESH_DIV);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    logic [1:0]    r_state;
    logic [31:0]   r_bin;
    logic [39:0]   r_bcd;
    logic [4:0]    r_step;
    logic          r_done;
    logic [6:0]    r_disp [0:7];
    logic [CW-1:0] r_refresh;
    logic [2:0]    r_idx;
    logic [6:0]    r_seg;
    logic [7:0]    r_an;

    logic [31:0]   w_load_mag;
    logic [35:0]   w_adj;
    logic [3:0]    w_msd;
    logic          w_ovf;
    logic [6:0]    w_img [0:7];

`ifdef RESULT_DISPLAY_SIGNED_EN
    logic          r_neg;

    // Magnitude of a negative operand; 32'h80000000 maps onto itself,
    // which read as unsigned is exactly 2147483648.
    assign w_load_mag = value[31] ? (~value + 32'd1) : value;
`else
    assign w_load_mag = value;
`endif

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign seg  = r_seg;
    assign an   = r_an;

    function automatic logic [6:0] f_seg(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'h40;
            4'd1:    c = 7'h79;
            4'd2:    c = 7'h24;
            4'd3:    c = 7'h30;
            4'd4:    c = 7'h19;
            4'd5:    c = 7'h12;
            4'd6:    c = 7'h02;
            4'd7:    c = 7'h78;
            4'd8:    c = 7'h00;
            4'd9:    c = 7'h10;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    // Add-3 correction on BCD digits 0..8 ahead of the shift. Digit 9
    // never exceeds 2 before the final shift, so it never needs fixing.
    always_comb begin
        w_adj = r_bcd[35:0];
        for (int i = 0; i < 9; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Turn the finished BCD accumulator into eight segment codes.
    always_comb begin
        w_msd = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_msd = 4'(i);
            end
        end

        w_ovf = (r_bcd[39:32] != 8'd0);
`ifdef RESULT_DISPLAY_SIGNED_EN
        // A negative result needs one spare position for the sign.
        if (r_neg && (r_bcd[31:28] != 4'd0)) begin
            w_ovf = 1'b1;
        end
`endif

        for (int i = 0; i < 8; i++) begin
            if (w_ovf) begin
                w_img[i] = SEG_DASH;
            end else if (4'(i) <= w_msd) begin
                w_img[i] = f_seg(r_bcd[4*i +: 4]);
`ifdef RESULT_DISPLAY_SIGNED_EN
            end else if (r_neg && (4'(i) == w_msd + 4'd1)) begin
                w_img[i] = SEG_DASH;
`endif
            end else begin
                w_img[i] = SEG_BLANK;
            end
        end
    end

    // Conversion FSM: capture, 32 shift-add-3 steps, then commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_bin   <= 32'd0;
            r_bcd   <= 40'd0;
            r_step  <= 5'd0;
            r_done  <= 1'b0;
`ifdef RESULT_DISPLAY_SIGNED_EN
            r_neg   <= 1'b0;
`endif
            r_disp[0] <= SEG_ZERO;
            for (int i = 1; i < 8; i++) begin
                r_disp[i] <= SEG_BLANK;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_bin   <= w_load_mag;
                        r_bcd   <= 40'd0;
                        r_step  <= 5'd0;
`ifdef RESULT_DISPLAY_SIGNED_EN
                        r_neg   <= value[31];
`endif
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_bcd  <= {r_bcd[38:36], w_adj, r_bin[31]};
                    r_bin  <= {r_bin[30:0], 1'b0};
                    r_step <= r_step + 5'd1;
                    if (r_step == 5'd31) begin
                        r_state <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    r_disp  <= w_img;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running digit scan; an and seg are both registered from the
    // same scan index so they always switch on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_refresh <= '0;
            r_idx     <= 3'd0;
            r_an      <= 8'hFE;
            r_seg     <= SEG_ZERO;
        end else begin
            if (r_refresh == CW'(REFRESH_DIV - 1)) begin
                r_refresh <= '0;
                r_idx     <= r_idx + 3'd1;
            end else begin
                r_refresh <= r_refresh + 1'b1;
            end
            r_an  <= ~(8'd1 << r_idx);
            r_seg <= r_disp[r_idx];
        end
    end

endmodule

// File: tb/tb_result_display.sv
// tb_result_display: random and directed loads of result_display, checked
// by a scoreboard against a decimal reference model of the display image.
module tb_result_display;

    localparam int DIV = 4;

    logic        clk;
    logic        reset;
    logic [31:0] value;
    logic        load;
    logic        busy;
    logic        done;
    logic [6:0]  seg;
    logic [7:0]  an;

    typedef struct {
        logic [55:0] img;
        int          ed;
    } exp_t;

    exp_t        q[$];
    logic [55:0] exp_img;
    int          cyc;
    int          last_acc;
    int          nchecks;
    int          nerrs;

    localparam logic [55:0] IMG_RST = {{7{7'h7F}}, 7'h40};

    result_display #(.REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .seg   (seg),
        .an    (an)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrs++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic logic [6:0] dig_code(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h10;
        endcase
    endfunction

    // Image from plain decimal arithmetic: digit i sits at bits [7i+:7].
    function automatic logic [55:0] ref_img(input logic [31:0] v);
        longint      mag;
        bit          neg;
        int          d[10];
        int          nd;
        int          lim;
        logic [55:0] r;
        mag = {32'd0, v};
        neg = 1'b0;
`ifdef RESULT_DISPLAY_SIGNED_EN
        if (v[31]) begin
            neg = 1'b1;
            mag = 64'd4294967296 - mag;
        end
`endif
        for (int i = 0; i < 10; i++) begin
            d[i] = int'(mag % 10);
            mag  = mag / 10;
        end
        nd = 1;
        for (int i = 0; i < 10; i++) begin
            if (d[i] != 0) nd = i + 1;
        end
        lim = neg ? 7 : 8;
        r = '0;
        for (int p = 0; p < 8; p++) begin
            if (nd > lim)             r[7*p +: 7] = 7'h3F;
            else if (p < nd)          r[7*p +: 7] = dig_code(d[p]);
            else if (neg && p == nd)  r[7*p +: 7] = 7'h3F;
            else                      r[7*p +: 7] = 7'h7F;
        end
        return r;
    endfunction

    // Called just after a falling edge; load is sampled on the next edge.
    // A load is taken only once the previous conversion has committed.
    task automatic do_load(input logic [31:0] v);
        int   e;
        exp_t x;
        e     = cyc + 1;
        value = v;
        load  = 1'b1;
        if (e >= last_acc + 34) begin
            x.img = ref_img(v);
            x.ed  = e;
            q.push_back(x);
            last_acc = e;
        end
        @(negedge clk);
        load  = 1'b0;
        value = $urandom;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_img();
        chk("rst_an",   {56'd0, an},   64'hFE);
        chk("rst_seg",  {57'd0, seg},  64'h40);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
    endtask

    // Monitor: busy/done/latency against the queue, and every scan slot
    // against the image committed by the most recent conversion.
    initial begin
        logic [7:0] prev_an;
        int         slot_len;
        bit         len_ok;
        int         last_evt;
        int         idx;
        int         pidx;
        bit         exp_busy;
        exp_t       x;
        prev_an  = 8'hFE;
        slot_len = 0;
        len_ok   = 1'b0;
        last_evt = 0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                prev_an  = 8'hFE;
                slot_len = 0;
                len_ok   = 1'b0;
                last_evt = cyc;
                continue;
            end
            exp_busy = (q.size() > 0) && (q[0].ed <= cyc) &&
                       (cyc < q[0].ed + 33);
            chk("busy", {63'd0, busy}, {63'd0, exp_busy});
            if (done) begin
                if (q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    x = q.pop_front();
                    chk("done_latency", 64'(cyc - x.ed), 64'd33);
                    exp_img = x.img;
                end
                last_evt = cyc;
            end else if (q.size() > 0 && cyc > q[0].ed + 33) begin
                chk("done_timeout", 64'd0, 64'd1);
                void'(q.pop_front());
            end
            slot_len++;
            if (an !== prev_an) begin
                idx = -1;
                for (int i = 0; i < 8; i++) begin
                    if (an === ~(8'd1 << i)) idx = i;
                end
                pidx = -1;
                for (int i = 0; i < 8; i++) begin
                    if (prev_an === ~(8'd1 << i)) pidx = i;
                end
                chk("an_order", 64'(idx), 64'((pidx + 1) % 8));
                if (len_ok) chk("slot_len", 64'(slot_len), 64'(DIV));
                if (idx >= 0 && cyc - last_evt >= 2) begin
                    chk($sformatf("seg_d%0d", idx), {57'd0, seg},
                        {57'd0, exp_img[7*idx +: 7]});
                end
                prev_an  = an;
                slot_len = 0;
                len_ok   = 1'b1;
            end
        end
    end

    initial begin
        int          gap;
        logic [31:0] rv;
        logic [31:0] corners[8];
        nchecks  = 0;
        nerrs    = 0;
        last_acc = -1000;
        exp_img  = IMG_RST;
        corners  = '{32'd0, 32'd99999999, 32'd100000000, 32'd10000000,
                     32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd9999999};
        reset = 1'b0;
        load  = 1'b0;
        value = 32'd0;
        wait_cyc(2);
        reset = 1'b1;
        chk_reset_img();
        wait_cyc(1);
        chk_reset_img();

        do_load(32'd12345678);
        wait_cyc(34 + 12 * DIV);
        do_load(32'd305);
        wait_cyc(34 + 12 * DIV);
        do_load(32'd0);
        wait_cyc(34 + 12 * DIV);
        do_load(32'hFFFFFFFF);
        wait_cyc(34 + 12 * DIV);

        do_load(32'd42);
        wait_cyc(9);
        do_load(32'd99);
        wait_cyc(30 + 12 * DIV);

        do_load(32'd7);
        wait_cyc(14);
        reset = 1'b0;
        wait_cyc(1);
        q.delete();
        exp_img  = IMG_RST;
        last_acc = -1000;
        wait_cyc(1);
        reset = 1'b1;
        chk_reset_img();
        wait_cyc(3);
        do_load(32'd7);
        wait_cyc(34 + 12 * DIV);

        do_load(32'd2024);
        wait_cyc(32);
        do_load(32'd31337);
        wait_cyc(34 + 12 * DIV);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       rv = $urandom_range(0, 999);
                1:       rv = $urandom_range(0, 99999999);
                2:       rv = $urandom;
                default: rv = corners[$urandom_range(0, 7)];
            endcase
            do_load(rv);
            gap = $urandom_range(0, 50);
            wait_cyc(gap);
            if ($urandom_range(0, 3) == 0) wait_cyc(34 + 10 * DIV);
        end

        wait_cyc(100);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrs);
        $finish;
    end

endmodule
